// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding,
// counter-width helper and the half-adder primitive.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= value; sizes the bit counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Half adder: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and the adder.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout, busy
  );
endinterface

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit full adder assembled from two half-adder stages and an OR.
module fa_cell
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic [1:0] ha0_s;
  logic [1:0] ha1_s;

  // First stage adds the operand bits, second folds in the carry.
  always_comb begin
    ha0_s = half_add(a, b);
    ha1_s = half_add(ha0_s[0], cin);
    s     = ha1_s[0];
    cout  = ha0_s[1] | ha1_s[1];
  end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop walk the operands
// LSB first, one bit per clock, behind valid/ready handshakes.
module bit_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  bit_serial_adder_if.slave bus
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state_r;
  state_t             next_state_s;
  logic [CNT_W-1:0]   count_r;
  logic               carry_r;
  logic [WIDTH-1:0]   a_sh_r;
  logic [WIDTH-1:0]   b_sh_r;
  logic [WIDTH-1:0]   sum_sh_r;
  logic [WIDTH-1:0]   s_r;
  logic               cout_r;
  logic               out_valid_r;
  logic               in_ready_r;
  logic               busy_r;
  logic               fa_s_s;
  logic               fa_cout_s;

  fa_cell u_fa (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .cin  (carry_r),
    .s    (fa_s_s),
    .cout (fa_cout_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.in_valid) next_state_s = S_RUN;
        else              next_state_s = S_IDLE;
      end
      S_RUN: begin
        if (count_r == LAST_BIT) next_state_s = S_DONE;
        else                     next_state_s = S_RUN;
      end
      S_DONE: begin
        if (bus.out_ready) next_state_s = S_IDLE;
        else               next_state_s = S_DONE;
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Datapath: operand load, per-bit shift/accumulate, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= '0;
      carry_r     <= 1'b0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      sum_sh_r    <= '0;
      s_r         <= '0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_sh_r  <= bus.a;
            b_sh_r  <= bus.b;
            carry_r <= bus.cin;
            count_r <= '0;
          end
        end
        S_RUN: begin
          carry_r  <= fa_cout_s;
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          sum_sh_r <= {fa_s_s, sum_sh_r[WIDTH-1:1]};
          if (count_r == LAST_BIT) begin
            // Counter wraps so it never holds a value above WIDTH-1.
            count_r     <= '0;
            s_r         <= {fa_s_s, sum_sh_r[WIDTH-1:1]};
            cout_r      <= fa_cout_s;
            out_valid_r <= 1'b1;
          end else begin
            count_r <= count_r + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Status flags registered from the upcoming state so they track it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      in_ready_r <= (next_state_s == S_IDLE);
      busy_r     <= (next_state_s == S_RUN) || (next_state_s == S_DONE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.s         = s_r;
  assign bus.cout      = cout_r;
  assign bus.busy      = busy_r;

endmodule
